// File: rtl/reg_file_sb.sv
// Register file with write-back scoreboard.
// Zero-latency reads with write-back bypass, and RAW/WAW stall on busy registers.
module reg_file_sb #(
   parameter int DATA_W  = 8,
   parameter bit ZERO_R0 = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        R1,
   input  logic [1:0]        R2,
   input  logic [1:0]        RW,
   input  logic              rd_en1,
   input  logic              rd_en2,
   input  logic              issue_valid,
   input  logic              issue_wr,
   output logic              issue_ready,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic              wb_valid,
   input  logic [1:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [3:0]        busy,
   output logic              wb_err
);

   logic [DATA_W-1:0] regs [4];
   logic [3:0]        clr;
   logic [3:0]        set;
   logic [3:0]        busy_n;
   logic              raw1;
   logic              raw2;
   logic              waw;
   logic              accept;
   logic              zero_wb;
   logic              err_n;

   assign clr = wb_valid ? (4'b0001 << wb_addr) : 4'b0000;

   assign raw1 = rd_en1 & busy[R1] & ~clr[R1];
   assign raw2 = rd_en2 & busy[R2] & ~clr[R2];
   assign waw  = issue_wr & busy[RW] & ~clr[RW];

   assign issue_ready = ~(raw1 | raw2 | waw);
   assign accept      = issue_valid & issue_ready;

   assign zero_wb = ZERO_R0 && (wb_addr == 2'd0);

   always_comb begin
      set = 4'b0000;
      if (accept && issue_wr)
         set = 4'b0001 << RW;
      if (ZERO_R0)
         set[0] = 1'b0;
   end

   // A reservation landing on the same edge as its clear survives.
   assign busy_n = (busy & ~clr) | set;

   assign err_n = wb_valid & ~busy[wb_addr] & ~zero_wb & ~set[wb_addr];

   always_comb begin
      rdata1 = regs[R1];
      if (wb_valid && (wb_addr == R1))
         rdata1 = wb_data;
      if (ZERO_R0 && (R1 == 2'd0))
         rdata1 = '0;
   end

   always_comb begin
      rdata2 = regs[R2];
      if (wb_valid && (wb_addr == R2))
         rdata2 = wb_data;
      if (ZERO_R0 && (R2 == 2'd0))
         rdata2 = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= 4'b0000;
         wb_err <= 1'b0;
      end else begin
         busy   <= busy_n;
         wb_err <= err_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++)
            regs[i] <= '0;
      end else if (wb_valid && !zero_wb) begin
         regs[wb_addr] <= wb_data;
      end
   end

endmodule
